ahblite_sys: RTL and testbench

Self-contained AHB-Lite system that mirrors an 8-bit switch input onto an 8-bit LED output through an internal bus. It contains a built-in sequencer master, an address decoder, a read-data mux, an LED register slave, a switch input slave and a default slave. It is the top level of the board-level peripheral demo; all bus signals stay internal.

---
 rtl/ahblite_sys_pkg.sv | 42 ++++
 rtl/ahblite_sys_if.sv | 24 ++
 rtl/ahb_reg8_slave.sv | 58 +++++
 rtl/ahblite_sys.sv | 133 +++++++++++++
 tb/tb_ahblite_sys.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/ahblite_sys_pkg.sv
// Shared AHB-Lite encodings, address map defaults, FSM/select enums and the
// slave response payload used by the ahblite_sys switch-to-LED demo.
package ahblite_sys_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    localparam logic [ADDR_W-1:0] LED_BASE_DEF = 32'h5000_0000;
    localparam logic [ADDR_W-1:0] SW_BASE_DEF  = 32'h5100_0000;

    typedef enum logic [1:0] {RD_A, RD_D, WR_A, WR_D} mst_state_e;
    typedef enum logic [1:0] {SEL_LED, SEL_SW, SEL_DEF} sel_e;

    // Data-phase response driven by each slave towards the read mux.
    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              ready;
        logic              resp;
    } ahb_rsp_t;

    // Region select on the top address byte; unmapped space goes to the default slave.
    function automatic sel_e decode(input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W-1:0] led_base,
                                    input logic [ADDR_W-1:0] sw_base);
        sel_e sel;
        sel = SEL_DEF;
        if (addr[31:24] == led_base[31:24]) begin
            sel = SEL_LED;
        end else if (addr[31:24] == sw_base[31:24]) begin
            sel = SEL_SW;
        end
        return sel;
    endfunction

endpackage

// File: rtl/ahblite_sys_if.sv
// Internal AHB-Lite bus: master-driven address/control/write data plus the
// muxed data-phase response.
interface ahblite_sys_if;
    import ahblite_sys_pkg::*;

    logic [ADDR_W-1:0] haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [DATA_W-1:0] hwdata;
    logic [DATA_W-1:0] hrdata;
    logic              hready;
    logic              hresp;

    modport master (
        output haddr, htrans, hwrite, hsize, hwdata,
        input  hrdata, hready, hresp
    );

    modport slave (
        input haddr, htrans, hwrite, hsize, hwdata, hready
    );

endinterface

// File: rtl/ahb_reg8_slave.sv
// Generic zero-wait 8-bit AHB-Lite register slave: either a bus-writable
// register or a read-only view of a 2-flop synchronized external input.
module ahb_reg8_slave
    import ahblite_sys_pkg::*;
#(
    parameter bit WRITABLE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    ahblite_sys_if.slave      bus,
    input  logic              sel,
    input  logic [BYTE_W-1:0] ext,
    output ahb_rsp_t          rsp_c
);

    logic [BYTE_W-1:0] data_q;
    logic              unused;

    assign rsp_c = '{rdata: DATA_W'(data_q), ready: 1'b1, resp: HRESP_OKAY};

    if (WRITABLE) begin : g_rw
        logic wr_q;

        // Address phase flags a write; the following data phase loads the byte.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_q   <= 1'b0;
                data_q <= '0;
            end else begin
                if (bus.hready) begin
                    wr_q <= sel && (bus.htrans == HTRANS_NONSEQ) && bus.hwrite;
                end
                if (wr_q && bus.hready) begin
                    data_q <= bus.hwdata[BYTE_W-1:0];
                end
            end
        end

        assign unused = ^{ext, bus.hwdata[DATA_W-1:BYTE_W], bus.haddr, bus.hsize};
    end else begin : g_ro
        logic [BYTE_W-1:0] meta_q;

        // Two-flop synchronizer; writes are ignored.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                meta_q <= '0;
                data_q <= '0;
            end else begin
                meta_q <= ext;
                data_q <= meta_q;
            end
        end

        assign unused = ^{sel, bus.haddr, bus.htrans, bus.hwrite, bus.hsize,
                          bus.hwdata, bus.hready};
    end

endmodule

// File: rtl/ahblite_sys.sv
// Switch-to-LED demo: sequencer master loops read SW slave / write LED slave
// over an internal AHB-Lite bus with decoder, response mux and default slave.
module ahblite_sys
    import ahblite_sys_pkg::*;
#(
    parameter logic [31:0] LED_BASE = LED_BASE_DEF,
    parameter logic [31:0] SW_BASE  = SW_BASE_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [BYTE_W-1:0] SW,
    output logic [BYTE_W-1:0] LED
);

    ahblite_sys_if bus ();

    mst_state_e        state_q, state_d;
    logic [BYTE_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] m_haddr;
    logic [1:0]        m_htrans;
    logic              m_hwrite;

    sel_e              sel_q;
    logic              act_q;
    logic              err_q;
    logic              def_act_c;
    logic              def_first_c;
    ahb_rsp_t          led_rsp_c, sw_rsp_c, def_rsp_c, rsp_c;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= RD_A;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // Sequencer: one transfer at a time, every state waits on HREADY.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        m_htrans = HTRANS_IDLE;
        m_hwrite = 1'b0;
        m_haddr  = SW_BASE;
        case (state_q)
            RD_A: begin
                m_htrans = HTRANS_NONSEQ;
                if (bus.hready) state_d = RD_D;
            end
            RD_D: begin
                if (bus.hready) begin
                    state_d = WR_A;
                    if (bus.hresp == HRESP_OKAY) data_d = bus.hrdata[BYTE_W-1:0];
                end
            end
            WR_A: begin
                m_htrans = HTRANS_NONSEQ;
                m_hwrite = 1'b1;
                m_haddr  = LED_BASE;
                if (bus.hready) state_d = WR_D;
            end
            WR_D: begin
                m_hwrite = 1'b1;
                m_haddr  = LED_BASE;
                if (bus.hready) state_d = RD_A;
            end
            default: state_d = RD_A;
        endcase
    end

    assign bus.haddr  = m_haddr;
    assign bus.htrans = m_htrans;
    assign bus.hwrite = m_hwrite;
    assign bus.hsize  = HSIZE_WORD;
    assign bus.hwdata = DATA_W'(data_q);

    // Address-phase select captured for steering the data-phase response.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sel_q <= SEL_DEF;
            act_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            if (bus.hready) begin
                sel_q <= decode(bus.haddr, LED_BASE, SW_BASE);
                act_q <= (bus.htrans == HTRANS_NONSEQ);
            end
            err_q <= def_first_c;
        end
    end

    // Default slave: two-cycle ERROR for active transfers, OKAY otherwise.
    assign def_act_c   = (sel_q == SEL_DEF) && act_q;
    assign def_first_c = def_act_c && !err_q;
    assign def_rsp_c   = '{rdata: '0, ready: !def_first_c,
                           resp: def_act_c ? HRESP_ERROR : HRESP_OKAY};

    always_comb begin
        rsp_c = def_rsp_c;
        case (sel_q)
            SEL_LED: rsp_c = led_rsp_c;
            SEL_SW:  rsp_c = sw_rsp_c;
            default: rsp_c = def_rsp_c;
        endcase
    end

    assign bus.hrdata = rsp_c.rdata;
    assign bus.hready = rsp_c.ready;
    assign bus.hresp  = rsp_c.resp;

    ahb_reg8_slave #(.WRITABLE(1'b1)) u_led (
        .clk   (CLK),
        .rst_n (RESET),
        .bus   (bus.slave),
        .sel   (decode(bus.haddr, LED_BASE, SW_BASE) == SEL_LED),
        .ext   (8'h00),
        .rsp_c (led_rsp_c)
    );

    ahb_reg8_slave #(.WRITABLE(1'b0)) u_sw (
        .clk   (CLK),
        .rst_n (RESET),
        .bus   (bus.slave),
        .sel   (decode(bus.haddr, LED_BASE, SW_BASE) == SEL_SW),
        .ext   (SW),
        .rsp_c (sw_rsp_c)
    );

    assign LED = led_rsp_c.rdata[BYTE_W-1:0];

endmodule

// File: tb/tb_ahblite_sys.sv
// Directed bench for ahblite_sys: reset/startup latency, SW steps, async
// reset, bus pattern and a forced access to unmapped space.
module tb_ahblite_sys;
    import ahblite_sys_pkg::*;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] SW;
    logic [7:0] LED;

    int vectors     = 0;
    int miscompares = 0;

    ahblite_sys dut (
        .CLK   (CLK),
        .RESET (RESET),
        .SW    (SW),
        .LED   (LED)
    );

    // Mirror of the internal bus for observation.
    ahblite_sys_if mon ();
    assign mon.haddr  = dut.bus.haddr;
    assign mon.htrans = dut.bus.htrans;
    assign mon.hwrite = dut.bus.hwrite;
    assign mon.hsize  = dut.bus.hsize;
    assign mon.hwdata = dut.bus.hwdata;
    assign mon.hrdata = dut.bus.hrdata;
    assign mon.hready = dut.bus.hready;
    assign mon.hresp  = dut.bus.hresp;

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next negedge where the master presents the SW read address phase.
    task automatic sync_rd_a(input string tag);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            @(negedge CLK);
            if (mon.htrans == HTRANS_NONSEQ && !mon.hwrite) found = 1'b1;
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    task automatic edges_then_check(input string tag, input int n, input logic [7:0] exp);
        repeat (n) @(posedge CLK);
        #1;
        chk(tag, 32'(LED), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1;
        SW    = 8'h11;
        #2 RESET = 1'b0;

        // Reset state, observed mid-reset.
        @(negedge CLK);
        chk("rst_led", 32'(LED), 32'h00);
        chk("rst_hready", 32'(mon.hready), 32'd1);
        chk("rst_hresp", 32'(mon.hresp), 32'(HRESP_OKAY));
        chk("rst_htrans", 32'(mon.htrans), 32'(HTRANS_NONSEQ));
        chk("rst_haddr", mon.haddr, 32'h5100_0000);

        #12 RESET = 1'b1;   // t=22, next edge is edge 1
        edges_then_check("led_edge4", 4, 8'h00);
        edges_then_check("led_edge7", 3, 8'h00);
        edges_then_check("led_edge8", 1, 8'h11);
        for (int i = 0; i < 6; i++) edges_then_check("led_stable", 1, 8'h11);

        // Bus pattern over 20 cycles.
        sync_rd_a("sync_mon");
        for (int i = 0; i < 20; i++) begin
            chk("mon_hready", 32'(mon.hready), 32'd1);
            case (i % 4)
                0: begin
                    chk("mon_htrans_rd", 32'(mon.htrans), 32'(HTRANS_NONSEQ));
                    chk("mon_haddr_rd", mon.haddr, 32'h5100_0000);
                    chk("mon_hwrite_rd", 32'(mon.hwrite), 32'd0);
                end
                1: begin
                    chk("mon_htrans_rdd", 32'(mon.htrans), 32'(HTRANS_IDLE));
                    chk("mon_hrdata", mon.hrdata, 32'h0000_0011);
                end
                2: begin
                    chk("mon_htrans_wr", 32'(mon.htrans), 32'(HTRANS_NONSEQ));
                    chk("mon_haddr_wr", mon.haddr, 32'h5000_0000);
                    chk("mon_hwrite_wr", 32'(mon.hwrite), 32'd1);
                end
                default: begin
                    chk("mon_htrans_wrd", 32'(mon.htrans), 32'(HTRANS_IDLE));
                    chk("mon_hwdata", mon.hwdata, 32'h0000_0011);
                end
            endcase
            @(negedge CLK);
        end

        // SW step: only old or new value may appear, new one within 10 cycles.
        SW = 8'hA5;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK);
            #1;
            chk("step_no_glitch", 32'(LED == 8'h11 || LED == 8'hA5), 32'd1);
        end
        chk("step_led_a5", 32'(LED), 32'hA5);

        // Asynchronous reset between edges.
        @(negedge CLK);
        SW = 8'h11;
        edges_then_check("pre_rst_led", 12, 8'h11);
        #2 RESET = 1'b0;
        #1;
        chk("async_rst_led", 32'(LED), 32'h00);
        chk("async_rst_htrans", 32'(mon.htrans), 32'(HTRANS_NONSEQ));
        chk("async_rst_haddr", mon.haddr, 32'h5100_0000);
        #3 RESET = 1'b1;
        edges_then_check("rerst_edge7", 7, 8'h00);
        edges_then_check("rerst_edge8", 1, 8'h11);

        // All ones then all zeros; upper read data must be zero on every read.
        @(negedge CLK);
        SW = 8'hFF;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (mon.htrans == HTRANS_IDLE && !mon.hwrite)
                chk("hrdata_upper_ff", 32'(mon.hrdata[31:8]), 32'd0);
        end
        chk("led_ff", 32'(LED), 32'hFF);
        SW = 8'h00;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (mon.htrans == HTRANS_IDLE && !mon.hwrite)
                chk("hrdata_upper_00", 32'(mon.hrdata[31:8]), 32'd0);
        end
        chk("led_00", 32'(LED), 32'h00);

        // Forced read of unmapped space: 2-cycle ERROR, read data discarded.
        sync_rd_a("sync_err");
        SW = 8'h3C;
        force dut.bus.haddr = 32'h6000_0000;
        @(posedge CLK);
        #1 release dut.bus.haddr;
        @(negedge CLK);
        chk("err1_hready", 32'(mon.hready), 32'd0);
        chk("err1_hresp", 32'(mon.hresp), 32'(HRESP_ERROR));
        @(negedge CLK);
        chk("err2_hready", 32'(mon.hready), 32'd1);
        chk("err2_hresp", 32'(mon.hresp), 32'(HRESP_ERROR));
        @(negedge CLK);
        chk("err_done_hresp", 32'(mon.hresp), 32'(HRESP_OKAY));
        chk("err_done_hready", 32'(mon.hready), 32'd1);
        edges_then_check("err_led_unchanged", 2, 8'h00);
        edges_then_check("err_led_recover", 4, 8'h3C);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
